// File: rtl/sudoku_pkg.sv
// Shared constants, FSM state type and box-index helper for the sudoku loader.
package sudoku_pkg;

   localparam int N        = 9;
   localparam int CELL_W   = 4;
   localparam int PUZZLE_W = N * N * CELL_W;
   localparam int CAND_W   = N * N * N;
   localparam logic [N-1:0] ALL_CAND = 9'h1FF;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      CONVERT,
      PRESENT
   } state_t;

   function automatic logic [3:0] box_of(input logic [3:0] row, input logic [3:0] col);
      return (row / 4'd3) * 4'd3 + col / 4'd3;
   endfunction

endpackage

// File: rtl/sudoku_cell_decode.sv
// Decodes one 4-bit puzzle cell into its 9-bit candidate mask plus given/bad flags.
module sudoku_cell_decode
   import sudoku_pkg::*;
(
   input  logic [CELL_W-1:0] digit,
   output logic [N-1:0]      mask,
   output logic              is_given,
   output logic              is_bad
);

   always_comb begin
      mask     = ALL_CAND;
      is_given = 1'b0;
      is_bad   = 1'b0;
      if (digit >= 4'd1 && digit <= 4'd9) begin
         mask     = 9'd1 << (digit - 4'd1);
         is_given = 1'b1;
      end else if (digit > 4'd9) begin
         is_bad = 1'b1;
      end
   end

endmodule

// File: rtl/sudoku_loader.sv
// Pops one packed puzzle, expands it row by row into a candidate-mask image and
// hands it to the solver core. Optional duplicate check: SUDOKU_LOADER_DUP_CHECK_EN.
module sudoku_loader
   import sudoku_pkg::*;
(
   input  logic                clk_150,
   input  logic                rst,
   input  logic                go,
   input  logic                ififo_rdempty,
   input  logic [PUZZLE_W-1:0] ififo_dataout,
   output logic                ififo_rdreq,
   output logic [CAND_W-1:0]   cand_out,
   output logic [6:0]          given_cnt,
   output logic                malformed,
   output logic                conflict,
   output logic                load_valid,
   input  logic                load_ready
);

   state_t              state_q, state_d;
   logic [3:0]          row_q, row_d;
   logic                rdreq_q, rdreq_d;
   logic                load_valid_q, load_valid_d;
   logic [CAND_W-1:0]   cand_q, cand_d;
   logic [6:0]          given_q, given_d;
   logic                malformed_q, malformed_d;
   logic [PUZZLE_W-1:0] puzzle_q, puzzle_d;

   logic [N*CELL_W-1:0] row_bits;
   logic [N-1:0]        cell_mask [N];
   logic [N-1:0]        cell_given;
   logic [N-1:0]        cell_bad;
   logic [N*N-1:0]      row_mask;
   logic [3:0]          row_given;

   always_comb begin
      row_bits = '0;
      for (int r = 0; r < N; r++) begin
         if (row_q == 4'(r)) row_bits = puzzle_q[PUZZLE_W-1-N*CELL_W*r -: N*CELL_W];
      end
   end

   for (genvar c = 0; c < N; c++) begin : g_dec
      sudoku_cell_decode u_dec (
         .digit    (row_bits[N*CELL_W-1-CELL_W*c -: CELL_W]),
         .mask     (cell_mask[c]),
         .is_given (cell_given[c]),
         .is_bad   (cell_bad[c])
      );
   end

   always_comb begin
      row_mask  = '0;
      row_given = '0;
      for (int c = 0; c < N; c++) begin
         row_mask[N*N-1-N*c -: N] = cell_mask[c];
         row_given = row_given + 4'(cell_given[c]);
      end
   end

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      rdreq_d      = 1'b0;
      load_valid_d = load_valid_q;
      cand_d       = cand_q;
      given_d      = given_q;
      malformed_d  = malformed_q;
      puzzle_d     = puzzle_q;
      case (state_q)
         IDLE: begin
            if (go && !ififo_rdempty) begin
               state_d = READ;
               rdreq_d = 1'b1;
            end
         end
         READ: state_d = CAPTURE;
         CAPTURE: begin
            puzzle_d    = ififo_dataout;
            given_d     = '0;
            malformed_d = 1'b0;
            row_d       = '0;
            state_d     = CONVERT;
         end
         CONVERT: begin
            for (int r = 0; r < N; r++) begin
               if (row_q == 4'(r)) cand_d[CAND_W-1-N*N*r -: N*N] = row_mask;
            end
            given_d     = given_q + 7'(row_given);
            malformed_d = malformed_q | (|cell_bad);
            if (row_q == 4'(N - 1)) begin
               row_d        = '0;
               load_valid_d = 1'b1;
               state_d      = PRESENT;
            end else begin
               row_d = row_q + 4'd1;
            end
         end
         PRESENT: begin
            if (load_ready) begin
               load_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_150 or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         rdreq_q      <= 1'b0;
         load_valid_q <= 1'b0;
         cand_q       <= '0;
         given_q      <= '0;
         malformed_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         rdreq_q      <= rdreq_d;
         load_valid_q <= load_valid_d;
         cand_q       <= cand_d;
         given_q      <= given_d;
         malformed_q  <= malformed_d;
      end
   end

   // Puzzle register is pure datapath; it is always reloaded in CAPTURE before use.
   always_ff @(posedge clk_150) begin
      puzzle_q <= puzzle_d;
   end

`ifdef SUDOKU_LOADER_DUP_CHECK_EN
   logic [N-1:0] col_seen_q [N];
   logic [N-1:0] col_seen_d [N];
   logic [N-1:0] box_seen_q [N];
   logic [N-1:0] box_seen_d [N];
   logic         conflict_q, conflict_d;

   // Same-row repeats are caught by row_acc; the seen-masks only hold earlier rows.
   always_comb begin
      logic [N-1:0] row_acc;
      logic [N-1:0] oh;
      logic [3:0]   b;
      logic         hit;
      row_acc    = '0;
      oh         = '0;
      b          = '0;
      hit        = 1'b0;
      col_seen_d = col_seen_q;
      box_seen_d = box_seen_q;
      for (int c = 0; c < N; c++) begin
         oh  = cell_given[c] ? cell_mask[c] : '0;
         b   = box_of(row_q, 4'(c));
         hit = hit | (|(oh & (row_acc | col_seen_q[c] | box_seen_q[b])));
         row_acc       = row_acc | oh;
         col_seen_d[c] = col_seen_q[c] | oh;
         box_seen_d[b] = box_seen_d[b] | oh;
      end
      conflict_d = conflict_q;
      if (state_q == CAPTURE) begin
         conflict_d = 1'b0;
         for (int i = 0; i < N; i++) begin
            col_seen_d[i] = '0;
            box_seen_d[i] = '0;
         end
      end else if (state_q == CONVERT) begin
         conflict_d = conflict_q | hit;
      end else begin
         col_seen_d = col_seen_q;
         box_seen_d = box_seen_q;
      end
   end

   always_ff @(posedge clk_150 or posedge rst) begin
      if (rst) begin
         conflict_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            col_seen_q[i] <= '0;
            box_seen_q[i] <= '0;
         end
      end else begin
         conflict_q <= conflict_d;
         col_seen_q <= col_seen_d;
         box_seen_q <= box_seen_d;
      end
   end

   assign conflict = conflict_q;
`else
   assign conflict = 1'b0;
`endif

   assign ififo_rdreq = rdreq_q;
   assign cand_out    = cand_q;
   assign given_cnt   = given_q;
   assign malformed   = malformed_q;
   assign load_valid  = load_valid_q;

endmodule

// File: tb/tb_sudoku_loader.sv
// Directed bench for sudoku_loader: FIFO model, latency/handshake timing, decode and reset.
`timescale 1ns/1ps
module tb_sudoku_loader;

   logic         clk_150 = 1'b0;
   logic         rst;
   logic         go;
   logic         ififo_rdempty;
   logic [323:0] ififo_dataout = '0;
   logic         ififo_rdreq;
   logic [728:0] cand_out;
   logic [6:0]   given_cnt;
   logic         malformed;
   logic         conflict;
   logic         load_valid;
   logic         load_ready;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [323:0] fmem [16];
   int           wr_ptr = 0;
   int           rd_ptr = 0;

   sudoku_loader dut (
      .clk_150       (clk_150),
      .rst           (rst),
      .go            (go),
      .ififo_rdempty (ififo_rdempty),
      .ififo_dataout (ififo_dataout),
      .ififo_rdreq   (ififo_rdreq),
      .cand_out      (cand_out),
      .given_cnt     (given_cnt),
      .malformed     (malformed),
      .conflict      (conflict),
      .load_valid    (load_valid),
      .load_ready    (load_ready)
   );

   always #3 clk_150 = ~clk_150;

   always @(posedge clk_150) cyc <= cyc + 1;

   // Normal-mode FIFO: data appears the cycle after the read strobe.
   assign ififo_rdempty = (rd_ptr == wr_ptr);
   always @(posedge clk_150) begin
      if (ififo_rdreq) begin
         ififo_dataout <= fmem[rd_ptr[3:0]];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   task automatic chk(input string tag, input logic [728:0] got, input logic [728:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [323:0] p);
      fmem[wr_ptr[3:0]] = p;
      wr_ptr++;
   endtask

   function automatic logic [323:0] put(input logic [323:0] p, input int r, input int c,
                                        input logic [3:0] d);
      p[323-4*(9*r+c) -: 4] = d;
      return p;
   endfunction

   function automatic logic [323:0] solved();
      logic [323:0] p;
      p = '0;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            p = put(p, r, c, 4'(((3*r + r/3 + c) % 9) + 1));
      return p;
   endfunction

   function automatic logic [728:0] exp_cand(input logic [323:0] p);
      logic [728:0] e;
      logic [3:0]   d;
      for (int i = 0; i < 81; i++) begin
         d = p[323-4*i -: 4];
         if (d >= 1 && d <= 9) e[728-9*i -: 9] = 9'd1 << (d - 1);
         else                  e[728-9*i -: 9] = 9'h1FF;
      end
      return e;
   endfunction

   task automatic wait_pop(output int t);
      t = -1;
      for (int k = 0; k < 60; k++) begin
         if (ififo_rdreq) begin
            t = cyc;
            return;
         end
         @(negedge clk_150);
      end
      chk("pop_seen", ififo_rdreq, 1'b1);
   endtask

   task automatic wait_valid(output int t);
      t = -1;
      for (int k = 0; k < 60; k++) begin
         if (load_valid) begin
            t = cyc;
            return;
         end
         @(negedge clk_150);
      end
      chk("valid_seen", load_valid, 1'b1);
   endtask

   initial begin
      logic [323:0] p_zero, p_sol, p_bad;
      logic [728:0] ones, snap_cand;
      logic [6:0]   snap_given;
      logic         snap_mal;
      int t0, t1, tv, x, pops, drops, moved;

      p_zero = '0;
      p_sol  = solved();
      p_bad  = put(p_zero, 4, 4, 4'hB);
      ones   = '1;

      rst = 1'b1; go = 1'b0; load_ready = 1'b0;
      repeat (2) @(negedge clk_150);
      chk("rst_rdreq", ififo_rdreq, 1'b0);
      chk("rst_valid", load_valid, 1'b0);
      chk("rst_cand", cand_out, '0);
      chk("rst_given", given_cnt, '0);
      chk("rst_malformed", malformed, 1'b0);
      chk("rst_conflict", conflict, 1'b0);
      rst = 1'b0;
      @(negedge clk_150);

      // All-zero puzzle
      push(p_zero);
      go = 1'b1;
      wait_pop(t0);
      @(negedge clk_150);
      chk("rdreq_one_cycle", ififo_rdreq, 1'b0);
      wait_valid(tv);
      chk("zero_latency", tv - t0, 11);
      chk("zero_cand", cand_out, ones);
      chk("zero_given", given_cnt, 7'd0);
      chk("zero_malformed", malformed, 1'b0);
      load_ready = 1'b1;
      @(negedge clk_150);
      chk("valid_drop", load_valid, 1'b0);

      // Solved grid twice, ready held high
      push(p_sol);
      push(p_sol);
      wait_pop(t0);
      wait_valid(tv);
      chk("sol_cand", cand_out, exp_cand(p_sol));
      chk("sol_cell00", cand_out[728 -: 9], 9'h001);
      chk("sol_cell88", cand_out[8:0], 9'h080);
      chk("sol_given", given_cnt, 7'd81);
      chk("sol_malformed", malformed, 1'b0);
      chk("sol_conflict", conflict, 1'b0);
      wait_pop(t1);
      chk("pop_spacing", t1 - t0, 13);
      wait_valid(tv);
      @(negedge clk_150);
      load_ready = 1'b0;

      // Malformed single cell, then backpressure
      push(p_bad);
      wait_pop(t0);
      wait_valid(tv);
      chk("bad_malformed", malformed, 1'b1);
      chk("bad_cell44", cand_out[728-9*40 -: 9], 9'h1FF);
      chk("bad_given", given_cnt, 7'd0);
      chk("bad_cand", cand_out, ones);
      push(p_sol);
      snap_cand = cand_out; snap_given = given_cnt; snap_mal = malformed;
      pops = 0; drops = 0; moved = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_150);
         if (ififo_rdreq) pops++;
         if (!load_valid) drops++;
         if (cand_out !== snap_cand || given_cnt !== snap_given || malformed !== snap_mal) moved++;
      end
      chk("bp_no_pop", pops, 0);
      chk("bp_valid_held", drops, 0);
      chk("bp_stable", moved, 0);
      x = cyc;
      load_ready = 1'b1;
      wait_pop(t0);
      chk("bp_release_pop", t0 - x, 2);
      load_ready = 1'b0;

      // Reset during CONVERT row 4
      repeat (6) @(negedge clk_150);
      chk("mid_given_rows0_3", given_cnt, 7'd36);
      rst = 1'b1;
      #1;
      chk("mrst_rdreq", ififo_rdreq, 1'b0);
      chk("mrst_valid", load_valid, 1'b0);
      chk("mrst_cand", cand_out, '0);
      chk("mrst_given", given_cnt, '0);
      chk("mrst_malformed", malformed, 1'b0);
      @(negedge clk_150);
      rst = 1'b0;
      push(p_sol);
      wait_pop(t0);
      wait_valid(tv);
      chk("post_rst_latency", tv - t0, 11);
      chk("post_rst_given", given_cnt, 7'd81);
      chk("post_rst_cand", cand_out, exp_cand(p_sol));
      load_ready = 1'b1;
      @(negedge clk_150);

`ifdef SUDOKU_LOADER_DUP_CHECK_EN
      push(put(put(p_zero, 0, 0, 4'd5), 0, 8, 4'd5));
      wait_pop(t0);
      wait_valid(tv);
      chk("dup_row", conflict, 1'b1);
      @(negedge clk_150);
      push(put(put(p_zero, 0, 0, 4'd5), 1, 1, 4'd5));
      wait_pop(t0);
      wait_valid(tv);
      chk("dup_box", conflict, 1'b1);
      @(negedge clk_150);
      push(put(put(p_zero, 0, 0, 4'd5), 4, 4, 4'd5));
      wait_pop(t0);
      wait_valid(tv);
      chk("dup_none", conflict, 1'b0);
      @(negedge clk_150);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
